multi_chan_buf_stub: RTL
========================

Name: multi_chan_buf_stub

Overview:
- Parametrised successor to the team's fixed two-channel 8-bit handshake stub DUT.
- Provides N_CH independent channels. Each has a valid/ready input side, a per-channel FIFO of DEPTH words, a configurable data transform and a valid/ready output side.
- Sits behind the generated VIP interfaces as the DUT for multi-agent UVM environments.
- Per-channel completed-transfer counters give the scoreboard a cross-check.

Parameters:
- N_CH, 2, number of independent channels (1..8).
- DATA_W, 8, data width per channel in bits (1..32).
- DEPTH, 4, FIFO depth per channel in words (power of two, 2..16).
- MODE, 0, transform applied at write: 0 pass-through, 1 bitwise invert, 2 add 1 modulo 2^DATA_W.
- CNT_W, 16, width of each per-channel transfer counter.

Ports:
- clk, input, 1, single clock; all state changes on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- valid_i, input, N_CH, per-channel input valid.
- ready_o, output, N_CH, per-channel input ready (registered).
- data_i, input, N_CH*DATA_W, channel c occupies bits [c*DATA_W +: DATA_W].
- valid_o, output, N_CH, per-channel output valid (FIFO not empty).
- ready_i, input, N_CH, per-channel output ready from consumer.
- data_o, output, N_CH*DATA_W, head-of-FIFO word per channel, same packing as data_i.
- xfer_cnt_o, output, N_CH*CNT_W, per-channel count of output transfers, channel c at [c*CNT_W +: CNT_W].

Behaviour:
- Interface: one clock clk; reset rst_n asynchronous, active-low. Asserting rst_n low immediately clears all state regardless of clock.
- Reset values: all FIFOs empty, all pointers 0, ready_o=0, valid_o=0, data_o=0, xfer_cnt_o=0.
- First rising edge with rst_n high: ready_o goes to all-ones.
- Channels are fully independent; no arbitration or shared state.
- Push on channel c: valid_i[c] && ready_o[c] at a rising edge.
  - Stored word = transform(data_i slice) per MODE.
  - Transform happens at write, not read.
- Pop on channel c: valid_o[c] && ready_i[c] at a rising edge. Head advances and xfer_cnt[c] increments.
- Counter wraps from 2^CNT_W-1 to 0 with no flag.
- Occupancy count per channel (0..DEPTH): +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- ready_o[c] is registered and always equals (count after this edge) != DEPTH.
  - Full channel: ready_o low.
  - A pop while full raises ready_o the next cycle.
  - No push is accepted in the cycle the FIFO is full, even if a pop occurs that cycle.
- valid_o[c] = (count != 0), derived from registered state.
- data_o = mem[rd_ptr] whenever valid_o=1; don't-care (hold last value) when empty.
- Latency: a word pushed at edge N is visible on data_o with valid_o=1 after edge N (zero-wait first-word fall-through from registers). Minimum input-to-output latency is 1 cycle.
- Empty with simultaneous push and pop is impossible (valid_o=0), so only the push takes effect.
- Pointers are log2(DEPTH) bits and wrap naturally; full/empty are decided by count, not by pointer compare.
- valid_i while ready_o=0: data is ignored and nothing is stored. The sender is required to hold it.
- X on data_i when valid_i=0 must not propagate into state.
- Reset mid-operation flushes all stored words. Nothing pushed before reset appears after it.

Test Plan:
- Reset then idle, N_CH=2: during rst_n=0, ready_o=2'b00, valid_o=2'b00, xfer_cnt_o=0; one edge after release, ready_o=2'b11.
- MODE=0, channel 0: push 0x11,0x22,0x33,0x44 with ready_i=0.
  - After the fourth push, ready_o[0]=0 and valid_o[0]=1.
  - A fifth push of 0x55 is not stored.
  - Raise ready_i: data_o reads 0x11,0x22,0x33,0x44 on consecutive cycles; xfer_cnt ch0 = 4.
- MODE=1 and MODE=2 builds: push 0xA5 -> data_o=0x5A (MODE=1) or 0xA6 (MODE=2); push 0xFF in MODE=2 -> 0x00.
- Full plus pop, DEPTH=4: with count=4, assert valid_i=1 and ready_i=1 in the same cycle.
  - Only the pop occurs; count=3 and ready_o=1 next cycle.
  - Next cycle, push and pop together: count stays 3.
- Channel independence: stream 100 random words on ch0 with ready_i[0] toggling randomly while ch1 stays idle.
  - ch1 valid_o=0 and xfer_cnt ch1=0 throughout.
  - ch0 output order matches the input order.
- Reset mid-stream: after 3 pushes on ch1, pulse rst_n low asynchronously between edges.
  - valid_o[1] drops immediately and xfer_cnt ch1 = 0.
  - After release, the first output word is the first word pushed after reset.
- Counter wrap, CNT_W=4: 17 transfers -> xfer_cnt=1.

Source files
------------

// File: rtl/multi_chan_buf_stub.sv
// N_CH independent valid/ready channels, each with a DEPTH-word first-word-fall-through FIFO,
// a write-side data transform and a wrapping completed-transfer counter.
module multi_chan_buf_stub #(
   parameter int N_CH   = 2,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int MODE   = 0,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH-1:0]          valid_i,
   output logic [N_CH-1:0]          ready_o,
   input  logic [N_CH*DATA_W-1:0]   data_i,
   output logic [N_CH-1:0]          valid_o,
   input  logic [N_CH-1:0]          ready_i,
   output logic [N_CH*DATA_W-1:0]   data_o,
   output logic [N_CH*CNT_W-1:0]    xfer_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH + 1);

   function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d);
      case (MODE)
         1:       return ~d;
         2:       return d + DATA_W'(1);
         default: return d;
      endcase
   endfunction

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [DATA_W-1:0] mem [DEPTH];
      logic [AW-1:0]     wr_ptr;
      logic [AW-1:0]     rd_ptr;
      logic [OW-1:0]     count;
      logic [OW-1:0]     count_nxt;
      logic [CNT_W-1:0]  cnt_q;
      logic              rdy_q;
      logic              push;
      logic              pop;

      // A full FIFO keeps rdy_q low, so a same-cycle pop never admits a push.
      assign push = valid_i[c] && rdy_q;
      assign pop  = (count != '0) && ready_i[c];

      // NOTE: every branch of a combinational block must assign its outputs; the default
      // first keeps count_nxt from being inferred as a latch.
      always_comb begin
         count_nxt = count;
         if (push && !pop)
            count_nxt = count + OW'(1);
         else if (pop && !push)
            count_nxt = count - OW'(1);
      end

      // NOTE: the storage array is cleared on reset so data_o reads zero out of reset;
      // this is affordable only because DEPTH is capped at 16 words.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         end else if (push) begin
            mem[wr_ptr] <= xform(data_i[c*DATA_W +: DATA_W]);
         end
      end

      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cnt_q  <= '0;
            rdy_q  <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
               cnt_q  <= cnt_q + CNT_W'(1);
            end
            count <= count_nxt;
            rdy_q <= (count_nxt != OW'(DEPTH));
         end
      end

      assign ready_o[c]                   = rdy_q;
      assign valid_o[c]                   = (count != '0);
      assign data_o[c*DATA_W +: DATA_W]   = mem[rd_ptr];
      assign xfer_cnt_o[c*CNT_W +: CNT_W] = cnt_q;
   end

endmodule
